gauss_frame_loader: RTL and testbench
=====================================

Name: gauss_frame_loader

Overview:
Upstream stage of the Gaussian filter. Accepts a raster-order pixel stream with valid/ready handshake and start-of-frame marker, and assembles it into a flat rows*cols frame register. Presents the frame with start/image_ready to the filter and holds it stable until the filter reports done. Also counts frames and flags protocol errors.

Parameters:
rows, 4, image height in pixels
cols, 4, image width in pixels
data_width, 8, bits per pixel

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pix_in  in  data_width  stream pixel
pix_valid  in  1  pix_in valid this cycle
pix_sof  in  1  qualifies first pixel of a frame; meaningful only with pix_valid
pix_ready  out  1  loader can accept a pixel
frame_out  out  data_width*rows*cols  assembled frame; pixel k at [k*data_width +: data_width]
filt_start  out  1  one-cycle start pulse to filter
filt_image_ready  out  1  frame complete and stable; held until filt_done
filt_done  in  1  filter completion pulse
frame_cnt  out  16  frames handed to filter, wraps at 65535 -> 0
sof_err  out  1  sticky: frame restarted by pix_sof before completion

Behaviour:
- Reset (async): state WAIT_SOF, index 0, frame_out 0, pix_ready 0, filt_start 0, filt_image_ready 0, frame_cnt 0, sof_err 0.
- Beat = pix_valid && pix_ready, sampled on posedge clk.
- WAIT_SOF: pix_ready=1. Beat without pix_sof: dropped, no state change. Beat with pix_sof: pixel written to slot 0, index<=1, go FILL. If rows*cols==1, go LAUNCH instead.
- FILL: pix_ready=1. Beat without sof: write slot index, index++. Beat on index==rows*cols-1: write, index<=0, go LAUNCH. Beat with sof: write slot 0, index<=1, set sof_err. Prior partial data is not cleared; it is overwritten.
- LAUNCH: pix_ready=0. filt_start=1 for exactly this one cycle. Go HOLD.
- HOLD: pix_ready=0, filt_image_ready=1, frame_out frozen. On filt_done: filt_image_ready<=0, frame_cnt++, go WAIT_SOF.
- filt_done outside HOLD: ignored.
- frame_out changes only on accepted beats; it is never cleared except by reset.
- Latency: last beat at cycle N -> filt_start high in cycle N+1 -> filt_image_ready high from N+2.
- Mid-operation reset: immediate return to reset values. The partial frame is lost.
- All outputs are registered.

Optional Feature:
Macro GAUSS_LOADER_PINGPONG_EN.
- Defined: two frame buffers. While HOLD presents buffer A, the loader keeps pix_ready=1 and fills buffer B using the same WAIT_SOF/FILL rules.
  - On filt_done with B complete, buffers swap and LAUNCH occurs the next cycle.
  - If B completes before filt_done, pix_ready=0 until the swap.
  - frame_out always shows the presented buffer.
- Undefined: single buffer, behaviour exactly as above.

Decomposition:
- Shared package gauss_pkg: state encoding localparams (WAIT_SOF, FILL, LAUNCH, HOLD), NPIX=rows*cols, index width $clog2(NPIX), frame_cnt width 16.
- One natural sub-module, gauss_frame_buf: indexed write port plus flat read port. Instantiated once, or twice under GAUSS_LOADER_PINGPONG_EN.

Test Plan:
- Reset, then stream pixels 0x01..0x10 with sof on 0x01, valid every cycle -> filt_start pulses once 1 cycle after last beat; frame_out=0x100F0E...0201; filt_image_ready high until filt_done; frame_cnt=1.
- 3 beats without sof, then a full frame -> first 3 dropped; frame_out matches the sof frame only.
- sof at pixel 0xA0, 5 beats, sof again at 0xB0 + 15 beats -> sof_err=1; frame_out slot0=0xB0; a single launch.
- Random pix_valid gaps (50%) and filt_done delayed 40 cycles -> pix_ready=0 and frame_out stable throughout HOLD; no extra filt_start.
- rst asserted mid-FILL (index 7) -> all outputs return to reset values asynchronously; next sof frame assembles correctly.
- With GAUSS_LOADER_PINGPONG_EN: two back-to-back frames, filt_done after second completes -> second launch 1 cycle after filt_done; frame_out switches to frame 2; frame_cnt=2.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared types and sizing for the Gaussian filter frame loader.
// Optional build macro used by the loader: GAUSS_LOADER_PINGPONG_EN.
package gauss_pkg;

    localparam int ROWS_DEF    = 4;
    localparam int COLS_DEF    = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int NPIX_DEF    = ROWS_DEF * COLS_DEF;
    localparam int FRAME_CNT_W = 16;

    // Outside ping-pong mode one FSM walks all four states. In ping-pong mode
    // the fill engine uses WAIT_SOF/FILL and the presenter uses
    // WAIT_SOF (idle)/LAUNCH/HOLD.
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        LAUNCH   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    function automatic int idx_width(input int npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NPIX_DEF);

endpackage

// File: rtl/gauss_frame_buf.sv
// Frame storage: one indexed pixel write port, whole frame readable as a flat vector.
module gauss_frame_buf #(
    parameter int npix       = 16,
    parameter int data_width = 8,
    parameter int idx_w      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [idx_w-1:0]           wr_idx,
    input  logic [data_width-1:0]      wr_data,
    output logic [npix*data_width-1:0] frame
);

    genvar gi;
    generate
        for (gi = 0; gi < npix; gi++) begin : g_slot
            logic [data_width-1:0] pix_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pix_reg <= '0;
                end else if (wr_en && (wr_idx == idx_w'(gi))) begin
                    pix_reg <= wr_data;
                end
            end

            assign frame[gi*data_width +: data_width] = pix_reg;
        end
    endgenerate

endmodule

// File: rtl/gauss_frame_loader.sv
// Assembles a raster pixel stream into a frame and hands it to the Gaussian filter.
// Build option: define GAUSS_LOADER_PINGPONG_EN for double-buffered capture.
module gauss_frame_loader
    import gauss_pkg::*;
#(
    parameter int rows       = ROWS_DEF,
    parameter int cols       = COLS_DEF,
    parameter int data_width = DATA_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [data_width-1:0]           pix_in,
    input  logic                            pix_valid,
    input  logic                            pix_sof,
    output logic                            pix_ready,
    output logic [data_width*rows*cols-1:0] frame_out,
    output logic                            filt_start,
    output logic                            filt_image_ready,
    input  logic                            filt_done,
    output logic [FRAME_CNT_W-1:0]          frame_cnt,
    output logic                            sof_err
);

    localparam int npix  = rows * cols;
    localparam int idx_w = idx_width(npix);
    localparam logic [idx_w-1:0] LAST_IDX = idx_w'(npix - 1);

    logic                   pix_ready_reg, pix_ready_next;
    logic                   filt_start_reg, filt_start_next;
    logic                   img_rdy_reg, img_rdy_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic                   sof_err_reg, sof_err_next;
    logic [idx_w-1:0]       idx_reg, idx_next;

    logic                   beat;
    logic                   wr_en;
    logic [idx_w-1:0]       wr_idx;

    assign beat = pix_valid && pix_ready_reg;

`ifdef GAUSS_LOADER_PINGPONG_EN

    state_t fstate_reg, fstate_next;
    state_t pstate_reg, pstate_next;
    logic   pres_sel_reg, pres_sel_next;
    logic   back_full_reg, back_full_next;
    logic   complete;
    logic [data_width*npix-1:0] frame0, frame1;

    // The fill side always targets the buffer not being presented.
    gauss_frame_buf #(.npix(npix), .data_width(data_width), .idx_w(idx_w)) u_buf0 (
        .clk(clk), .rst(rst), .wr_en(wr_en && pres_sel_reg), .wr_idx(wr_idx),
        .wr_data(pix_in), .frame(frame0)
    );
    gauss_frame_buf #(.npix(npix), .data_width(data_width), .idx_w(idx_w)) u_buf1 (
        .clk(clk), .rst(rst), .wr_en(wr_en && !pres_sel_reg), .wr_idx(wr_idx),
        .wr_data(pix_in), .frame(frame1)
    );

    assign frame_out = pres_sel_reg ? frame1 : frame0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_reg    <= WAIT_SOF;
            pstate_reg    <= WAIT_SOF;
            pres_sel_reg  <= 1'b0;
            back_full_reg <= 1'b0;
        end else begin
            fstate_reg    <= fstate_next;
            pstate_reg    <= pstate_next;
            pres_sel_reg  <= pres_sel_next;
            back_full_reg <= back_full_next;
        end
    end

    always_comb begin
        fstate_next    = fstate_reg;
        pstate_next    = pstate_reg;
        pres_sel_next  = pres_sel_reg;
        back_full_next = back_full_reg;
        idx_next       = idx_reg;
        frame_cnt_next = frame_cnt_reg;
        sof_err_next   = sof_err_reg;
        wr_en          = 1'b0;
        wr_idx         = idx_reg;
        complete       = 1'b0;

        case (fstate_reg)
            FILL: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        wr_idx       = '0;
                        idx_next     = idx_w'(1);
                        sof_err_next = 1'b1;
                    end else if (idx_reg == LAST_IDX) begin
                        idx_next    = '0;
                        fstate_next = WAIT_SOF;
                        complete    = 1'b1;
                    end else begin
                        idx_next = idx_reg + idx_w'(1);
                    end
                end
            end
            default: begin
                if (beat && pix_sof) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (npix == 1) begin
                        complete = 1'b1;
                    end else begin
                        idx_next    = idx_w'(1);
                        fstate_next = FILL;
                    end
                end
            end
        endcase

        case (pstate_reg)
            LAUNCH: begin
                pstate_next = HOLD;
                if (complete) back_full_next = 1'b1;
            end
            HOLD: begin
                if (filt_done) begin
                    frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
                    if (back_full_reg || complete) begin
                        pres_sel_next  = !pres_sel_reg;
                        back_full_next = 1'b0;
                        pstate_next    = LAUNCH;
                    end else begin
                        pstate_next = WAIT_SOF;
                    end
                end else if (complete) begin
                    back_full_next = 1'b1;
                end
            end
            default: begin
                if (complete) begin
                    pres_sel_next = !pres_sel_reg;
                    pstate_next   = LAUNCH;
                end
            end
        endcase

        pix_ready_next  = !back_full_next;
        filt_start_next = (pstate_next == LAUNCH);
        img_rdy_next    = (pstate_next == HOLD);
    end

`else

    state_t state_reg, state_next;

    gauss_frame_buf #(.npix(npix), .data_width(data_width), .idx_w(idx_w)) u_buf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(pix_in), .frame(frame_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WAIT_SOF;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        frame_cnt_next = frame_cnt_reg;
        sof_err_next   = sof_err_reg;
        wr_en          = 1'b0;
        wr_idx         = idx_reg;

        case (state_reg)
            WAIT_SOF: begin
                // Beats without sof are consumed and discarded here.
                if (beat && pix_sof) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (npix == 1) begin
                        state_next = LAUNCH;
                    end else begin
                        idx_next   = idx_w'(1);
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        wr_idx       = '0;
                        idx_next     = idx_w'(1);
                        sof_err_next = 1'b1;
                    end else if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = LAUNCH;
                    end else begin
                        idx_next = idx_reg + idx_w'(1);
                    end
                end
            end
            LAUNCH: begin
                state_next = HOLD;
            end
            default: begin
                if (filt_done) begin
                    frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
                    state_next     = WAIT_SOF;
                end
            end
        endcase

        pix_ready_next  = (state_next == WAIT_SOF) || (state_next == FILL);
        filt_start_next = (state_next == LAUNCH);
        img_rdy_next    = (state_next == HOLD);
    end

`endif

    // Handshake/status outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg        <= '0;
            pix_ready_reg  <= 1'b0;
            filt_start_reg <= 1'b0;
            img_rdy_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
            sof_err_reg    <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            pix_ready_reg  <= pix_ready_next;
            filt_start_reg <= filt_start_next;
            img_rdy_reg    <= img_rdy_next;
            frame_cnt_reg  <= frame_cnt_next;
            sof_err_reg    <= sof_err_next;
        end
    end

    assign pix_ready        = pix_ready_reg;
    assign filt_start       = filt_start_reg;
    assign filt_image_ready = img_rdy_reg;
    assign frame_cnt        = frame_cnt_reg;
    assign sof_err          = sof_err_reg;

endmodule

// File: tb/tb_gauss_frame_loader.sv
// Scoreboard bench for gauss_frame_loader (4x4 frame, 8-bit pixels).
module tb_gauss_frame_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         pix_sof = 1'b0;
    logic         pix_ready;
    logic [127:0] frame_out;
    logic         filt_start;
    logic         filt_image_ready;
    logic         filt_done = 1'b0;
    logic [15:0]  frame_cnt;
    logic         sof_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] frame;
        logic [15:0]  cnt;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] held_frame = '0;

    always #5 clk = ~clk;

    gauss_frame_loader dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .frame_out(frame_out),
        .filt_start(filt_start), .filt_image_ready(filt_image_ready),
        .filt_done(filt_done), .frame_cnt(frame_cnt), .sof_err(sof_err)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) f[k*8 +: 8] = base + 8'(k);
        return f;
    endfunction

    // Monitor: pops one expectation per launch; checks hold-phase stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (filt_start) begin
                if (exp_q.size() == 0) begin
                    chk("extra_start", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("launch: frame=%h cnt=%0d sof_err=%0b", frame_out, frame_cnt, sof_err);
                    chk("launch_frame", frame_out, e.frame);
                    chk("launch_cnt", 128'(frame_cnt), 128'(e.cnt));
                    chk("launch_sof_err", 128'(sof_err), 128'(e.err));
                    chk("launch_img_rdy_low", 128'(filt_image_ready), 128'd0);
                end
                held_frame = frame_out;
            end
            if (filt_image_ready) begin
                chk("hold_frame", frame_out, held_frame);
`ifndef GAUSS_LOADER_PINGPONG_EN
                chk("hold_pix_ready", 128'(pix_ready), 128'd0);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat with valid still high.
    task automatic send_pix(input logic [7:0] d, input logic s, input bit gap);
        int n;
        if (gap && ($urandom_range(0, 1) == 1)) begin
            pix_valid = 1'b0;
            @(negedge clk);
        end
        pix_in = d;
        pix_sof = s;
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) chk("pix_ready_timeout", 128'd0, 128'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gap, input bit chk_lat);
        for (int k = 0; k < 16; k++) send_pix(base + 8'(k), k == 0, gap);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        if (chk_lat) chk("start_latency", 128'(filt_start), 128'd1);
    endtask

    task automatic push_exp(input logic [127:0] f, input logic [15:0] c, input logic e);
        exp_t x;
        x.frame = f;
        x.cnt = c;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_img_rdy();
        int n;
        n = 0;
        while (!filt_image_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!filt_image_ready) chk("img_rdy_timeout", 128'd0, 128'd1);
    endtask

    task automatic pulse_done(input int delay, input logic [15:0] cnt_exp, input bit launch_exp);
        wait_img_rdy();
        repeat (delay) @(negedge clk);
        filt_done = 1'b1;
        @(negedge clk);
        filt_done = 1'b0;
        $display("done: frame_cnt=%0d", frame_cnt);
        chk("done_img_rdy_low", 128'(filt_image_ready), 128'd0);
        chk("done_frame_cnt", 128'(frame_cnt), 128'(cnt_exp));
        chk("done_start", 128'(filt_start), 128'(launch_exp));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_frame"}, frame_out, 128'd0);
        chk({tag, "_pix_ready"}, 128'(pix_ready), 128'd0);
        chk({tag, "_start"}, 128'(filt_start), 128'd0);
        chk({tag, "_img_rdy"}, 128'(filt_image_ready), 128'd0);
        chk({tag, "_cnt"}, 128'(frame_cnt), 128'd0);
        chk({tag, "_sof_err"}, 128'(sof_err), 128'd0);
    endtask

    logic [127:0] f3;

    initial begin
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // filt_done outside HOLD must not count
        filt_done = 1'b1;
        @(negedge clk);
        filt_done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", 128'(frame_cnt), 128'd0);

`ifdef GAUSS_LOADER_PINGPONG_EN
        // Two back-to-back frames; second fills while first is held
        push_exp(ramp(8'h70), 16'd0, 1'b0);
        push_exp(ramp(8'h80), 16'd1, 1'b0);
        send_frame(8'h70, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("pp_back_full_ready", 128'(pix_ready), 128'd0);
        pulse_done(2, 16'd1, 1'b1);
        pulse_done(5, 16'd2, 1'b0);
`else
        // T1: plain ramp 0x01..0x10
        push_exp(ramp(8'h01), 16'd0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1);
        pulse_done(3, 16'd1, 1'b0);

        // T2: three orphan beats are dropped
        for (int k = 0; k < 3; k++) send_pix(8'hE0 + 8'(k), 1'b0, 1'b0);
        pix_valid = 1'b0;
        push_exp(ramp(8'h20), 16'd1, 1'b0);
        send_frame(8'h20, 1'b0, 1'b1);
        pulse_done(2, 16'd2, 1'b0);

        // T3: restart by sof after 5 beats
        f3 = ramp(8'hB0);
        push_exp(f3, 16'd2, 1'b1);
        for (int k = 0; k < 5; k++) send_pix(8'hA0 + 8'(k), k == 0, 1'b0);
        send_frame(8'hB0, 1'b0, 1'b1);
        chk("restart_slot0", 128'(frame_out[7:0]), 128'hB0);
        pulse_done(1, 16'd3, 1'b0);

        // T4: random gaps, stalled filter, stream pushes during HOLD
        push_exp(ramp(8'h40), 16'd3, 1'b1);
        send_frame(8'h40, 1'b1, 1'b1);
        wait_img_rdy();
        pix_in = 8'hFF;
        pix_sof = 1'b1;
        pix_valid = 1'b1;
        repeat (40) @(negedge clk);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pulse_done(0, 16'd4, 1'b0);

        // T5: async reset at index 7, then clean frame
        for (int k = 0; k < 7; k++) send_pix(8'h50 + 8'(k), k == 0, 1'b0);
        pix_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b0;
        push_exp(ramp(8'h60), 16'd0, 1'b0);
        send_frame(8'h60, 1'b0, 1'b1);
        pulse_done(2, 16'd1, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
